// File: rtl/sd_pkg.sv
// Shared definitions for the SD sector reader: FSM states, protocol bytes,
// error codes and the CMD17 frame builder.
package sd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_R1,
        ST_TOKEN,
        ST_DATA,
        ST_CRC,
        ST_TAIL,
        ST_DONE,
        ST_ERROR,
        ST_DRAIN     // abort requested, waiting for the outstanding byte
    } state_t;

    localparam logic [7:0] CMD17_BYTE  = 8'h51;
    localparam logic [7:0] TOKEN_START = 8'hFE;
    localparam logic [7:0] CMD_CRC     = 8'hFF;
    localparam logic [7:0] POLL_BYTE   = 8'hFF;
    localparam int         SECTOR_BYTES = 512;
    localparam int         CMD_BYTES    = 6;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_R1       = 3'd1;
    localparam logic [2:0] ERR_R1_TO    = 3'd2;
    localparam logic [2:0] ERR_TOKEN    = 3'd3;
    localparam logic [2:0] ERR_TOKEN_TO = 3'd4;
    localparam logic [2:0] ERR_BAD      = 3'd5;

    // Byte idx of the CMD17 frame: opcode, 4 argument bytes MSB first, dummy CRC.
    function automatic logic [7:0] cmd_byte(input logic [2:0] idx, input logic [31:0] arg);
        case (idx)
            3'd0:    cmd_byte = CMD17_BYTE;
            3'd1:    cmd_byte = arg[31:24];
            3'd2:    cmd_byte = arg[23:16];
            3'd3:    cmd_byte = arg[15:8];
            3'd4:    cmd_byte = arg[7:0];
            default: cmd_byte = CMD_CRC;
        endcase
    endfunction

endpackage

// File: rtl/sd_byte_xfer.sv
// One-byte-at-a-time handshake towards the SPI master.
//   req/tx    : FSM asks for an exchange of byte tx (taken only when idle)
//   hold      : blocks new exchanges, used while an abort drains
//   done/rx   : exchange finished this cycle, rx is the received byte
//   idle      : no byte outstanding
//   spi_send/spi_tx/spi_rx/spi_avail : SPI master byte port
module sd_byte_xfer
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       hold,
    input  logic [7:0] tx,
    output logic       done,
    output logic [7:0] rx,
    output logic       idle,
    output logic       spi_send,
    output logic [7:0] spi_tx,
    input  logic [7:0] spi_rx,
    input  logic       spi_avail
);

    logic pending;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= 1'b0;
            spi_send <= 1'b0;
            spi_tx   <= POLL_BYTE;
        end else begin
            spi_send <= 1'b0;
            if (!pending) begin
                if (req && !hold) begin
                    spi_send <= 1'b1;
                    spi_tx   <= tx;   // held until the exchange completes
                    pending  <= 1'b1;
                end
            end else if (spi_avail) begin
                pending <= 1'b0;
            end
        end
    end

    // A stray spi_avail while nothing is outstanding is ignored.
    assign done = pending && spi_avail;
    assign rx   = spi_rx;
    assign idle = !pending;

endmodule

// File: rtl/sd_block_reader.sv
// Reads one 512-byte SD sector with CMD17 over the SPI master byte port and
// streams the payload out.
//   iStart/iLba/iSdhc : request, sector number, addressing mode
//   iAbort            : cancel; the outstanding byte is drained first
//   oBusy/oDone/oError/oErrCode : status
//   oData/oValid/oIdx : payload stream, one strobe per byte
//   oSpiSend/oSpiTx/iSpiRx/iSpiAvail : SPI master byte port
//   oSdCs             : card chip select, active low
module sd_block_reader
    import sd_pkg::*;
#(
    parameter int unsigned R1_TIMEOUT    = 16,
    parameter int unsigned TOKEN_TIMEOUT = 4096
) (
    input  logic        iClk,
    input  logic        iRstN,
    input  logic        iStart,
    input  logic        iAbort,
    input  logic [31:0] iLba,
    input  logic        iSdhc,
    output logic        oBusy,
    output logic        oDone,
    output logic        oError,
    output logic [2:0]  oErrCode,
    output logic [7:0]  oData,
    output logic        oValid,
    output logic [8:0]  oIdx,
    output logic        oSpiSend,
    output logic [7:0]  oSpiTx,
    input  logic [7:0]  iSpiRx,
    input  logic        iSpiAvail,
    output logic        oSdCs
);

    localparam logic [15:0] CMD_LAST  = 16'(CMD_BYTES - 1);
    localparam logic [15:0] DATA_LAST = 16'(SECTOR_BYTES - 1);

    state_t      state, state_next;
    logic [15:0] cnt;          // bytes sent in CMD/DATA/CRC, completed polls in R1/TOKEN
    logic [15:0] cnt_inc;
    logic [31:0] arg;
    logic [2:0]  err_val;
    logic        active;
    logic        xfer_req, xfer_hold, xfer_done, xfer_idle;
    logic [7:0]  xfer_tx, xfer_rx;

    sd_byte_xfer u_xfer (
        .clk       (iClk),
        .rst_n     (iRstN),
        .req       (xfer_req),
        .hold      (xfer_hold),
        .tx        (xfer_tx),
        .done      (xfer_done),
        .rx        (xfer_rx),
        .idle      (xfer_idle),
        .spi_send  (oSpiSend),
        .spi_tx    (oSpiTx),
        .spi_rx    (iSpiRx),
        .spi_avail (iSpiAvail)
    );

    assign cnt_inc = cnt + 16'd1;
    assign active  = state inside {ST_CMD, ST_R1, ST_TOKEN, ST_DATA, ST_CRC, ST_TAIL};

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) state <= ST_IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        xfer_req   = 1'b0;
        xfer_hold  = 1'b0;
        xfer_tx    = POLL_BYTE;
        err_val    = ERR_NONE;
        if (active) begin
            // Back-to-back requests are fine: the byte engine only accepts
            // one while idle, i.e. the cycle after the previous completion.
            xfer_req  = 1'b1;
            xfer_hold = iAbort;
        end
        case (state)
            ST_IDLE: if (iStart) state_next = ST_CMD;
            ST_CMD: begin
                xfer_tx = cmd_byte(cnt[2:0], arg);
                if (xfer_done && cnt == CMD_LAST) state_next = ST_R1;
            end
            ST_R1: if (xfer_done) begin
                if (xfer_rx[7]) begin
                    if (32'(cnt_inc) >= R1_TIMEOUT) begin
                        state_next = ST_ERROR;
                        err_val    = ERR_R1_TO;
                    end
                end else if (xfer_rx == 8'h00) begin
                    state_next = ST_TOKEN;
                end else begin
                    state_next = ST_ERROR;
                    err_val    = ERR_R1;
                end
            end
            ST_TOKEN: if (xfer_done) begin
                if (xfer_rx == TOKEN_START) begin
                    state_next = ST_DATA;
                end else if (xfer_rx == 8'hFF) begin
                    if (32'(cnt_inc) >= TOKEN_TIMEOUT) begin
                        state_next = ST_ERROR;
                        err_val    = ERR_TOKEN_TO;
                    end
                end else if (xfer_rx[7:4] == 4'h0 && xfer_rx != 8'h00) begin
                    state_next = ST_ERROR;
                    err_val    = ERR_TOKEN;
                end else begin
                    state_next = ST_ERROR;
                    err_val    = ERR_BAD;
                end
            end
            ST_DATA:  if (xfer_done && cnt == DATA_LAST) state_next = ST_CRC;
            ST_CRC:   if (xfer_done && cnt == 16'd1) state_next = ST_TAIL;
            ST_TAIL:  if (xfer_done) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            ST_ERROR: state_next = ST_IDLE;
            ST_DRAIN: if (xfer_idle || xfer_done) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        // Abort wins over whatever the byte just completed would have done.
        if (active && iAbort) begin
            state_next = ST_DRAIN;
            err_val    = ERR_NONE;
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            cnt      <= 16'd0;
            arg      <= 32'd0;
            oSdCs    <= 1'b1;
            oBusy    <= 1'b0;
            oDone    <= 1'b0;
            oError   <= 1'b0;
            oErrCode <= ERR_NONE;
            oData    <= 8'd0;
            oValid   <= 1'b0;
            oIdx     <= 9'd0;
        end else begin
            oDone  <= 1'b0;
            oError <= 1'b0;
            oValid <= 1'b0;
            case (state)
                ST_IDLE: if (iStart) begin
                    // Byte addressing drops LBA[31:23]; the shift truncates them.
                    arg      <= iSdhc ? iLba : {iLba[22:0], 9'd0};
                    oErrCode <= ERR_NONE;
                    oSdCs    <= 1'b0;
                    oBusy    <= 1'b1;
                    cnt      <= 16'd0;
                end
                ST_DONE: begin
                    oDone <= 1'b1;
                    oBusy <= 1'b0;
                end
                ST_ERROR: begin
                    oError <= 1'b1;
                    oBusy  <= 1'b0;
                    oSdCs  <= 1'b1;
                end
                ST_DRAIN: if (state_next == ST_IDLE) begin
                    oSdCs <= 1'b1;
                    oBusy <= 1'b0;
                end
                default: if (xfer_done && !iAbort) begin
                    if (state == ST_DATA) begin
                        oData  <= xfer_rx;
                        oValid <= 1'b1;
                        oIdx   <= cnt[8:0];
                    end
                    cnt <= (state_next == state) ? cnt_inc : 16'd0;
                    // CS goes high before the tail byte so the card releases MISO.
                    if (state_next == ST_TAIL) oSdCs <= 1'b1;
                end
            endcase
            if (state_next == ST_ERROR) oErrCode <= err_val;
        end
    end

endmodule

// File: tb/tb_sd_block_reader.sv
// Scoreboard bench for sd_block_reader: a reference model expands each read
// scenario into the expected SPI byte stream, payload stream and ending; a
// card model answers every SPI exchange; monitors pop and compare.
module tb_sd_block_reader;

    localparam int R1_TO  = 16;
    localparam int TOK_TO = 4096;

    logic        iClk = 1'b0, iRstN = 1'b0, iStart = 1'b0, iAbort = 1'b0, iSdhc = 1'b0;
    logic [31:0] iLba = 32'd0;
    logic [7:0]  iSpiRx = 8'hFF;
    logic        iSpiAvail = 1'b0;
    logic        oBusy, oDone, oError, oValid, oSpiSend, oSdCs;
    logic [2:0]  oErrCode;
    logic [7:0]  oData, oSpiTx;
    logic [8:0]  oIdx;

    always #5 iClk = ~iClk;

    sd_block_reader #(.R1_TIMEOUT(R1_TO), .TOKEN_TIMEOUT(TOK_TO)) dut (
        .iClk(iClk), .iRstN(iRstN), .iStart(iStart), .iAbort(iAbort),
        .iLba(iLba), .iSdhc(iSdhc), .oBusy(oBusy), .oDone(oDone),
        .oError(oError), .oErrCode(oErrCode), .oData(oData), .oValid(oValid),
        .oIdx(oIdx), .oSpiSend(oSpiSend), .oSpiTx(oSpiTx), .iSpiRx(iSpiRx),
        .iSpiAvail(iSpiAvail), .oSdCs(oSdCs)
    );

    typedef struct packed { logic [7:0] b; logic cs; } tx_t;

    tx_t         exp_tx[$];    // expected byte + chip select per oSpiSend
    logic [7:0]  rx_q[$];      // card answers, one per exchange
    logic [16:0] exp_data[$];  // {idx, byte} per oValid
    int          exp_end[$];   // 0 = oDone, else expected oErrCode

    int checks = 0, errors = 0;
    int ends_seen = 0, sends_seen = 0;
    int card_delay = 0;        // 0: random 1..3 cycles

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_x(input logic [7:0] b, input logic cs, input logic [7:0] r);
        exp_tx.push_back('{b: b, cs: cs});
        rx_q.push_back(r);
    endtask

    task automatic flush();
        exp_tx.delete();
        rx_q.delete();
        exp_data.delete();
        exp_end.delete();
    endtask

    // Reference model: the protocol as a list of exchanges.
    task automatic build_read(input logic [31:0] lba, input logic sdhc,
                              input int r1_pre, input logic [7:0] r1_val,
                              input int tok_pre, input logic [7:0] tok_val,
                              input bit ramp);
        logic [31:0] a;
        logic [7:0]  resp, b;
        int          polls;
        bit          go, ok;
        a = sdhc ? lba : (lba << 9);
        push_x(8'h51, 1'b0, 8'hFF);
        push_x(a[31:24], 1'b0, 8'hFF);
        push_x(a[23:16], 1'b0, 8'hFF);
        push_x(a[15:8],  1'b0, 8'hFF);
        push_x(a[7:0],   1'b0, 8'hFF);
        push_x(8'hFF,    1'b0, 8'hFF);
        polls = 0; go = 1'b1; ok = 1'b0;
        while (go) begin
            resp = (polls < r1_pre) ? 8'hFF : r1_val;
            polls++;
            push_x(8'hFF, 1'b0, resp);
            if (resp[7]) begin
                if (polls >= R1_TO) begin exp_end.push_back(2); go = 1'b0; end
            end else if (resp == 8'h00) begin
                ok = 1'b1; go = 1'b0;
            end else begin
                exp_end.push_back(1); go = 1'b0;
            end
        end
        if (!ok) return;
        polls = 0; go = 1'b1; ok = 1'b0;
        while (go) begin
            resp = (polls < tok_pre) ? 8'hFF : tok_val;
            polls++;
            push_x(8'hFF, 1'b0, resp);
            if (resp == 8'hFE) begin
                ok = 1'b1; go = 1'b0;
            end else if (resp == 8'hFF) begin
                if (polls >= TOK_TO) begin exp_end.push_back(4); go = 1'b0; end
            end else begin
                exp_end.push_back((resp >= 8'h01 && resp <= 8'h0F) ? 3 : 5);
                go = 1'b0;
            end
        end
        if (!ok) return;
        for (int k = 0; k < 512; k++) begin
            b = ramp ? k[7:0] : 8'($urandom);
            push_x(8'hFF, 1'b0, b);
            exp_data.push_back({k[8:0], b});
        end
        push_x(8'hFF, 1'b0, 8'($urandom));
        push_x(8'hFF, 1'b0, 8'($urandom));
        push_x(8'hFF, 1'b1, 8'hFF);
        exp_end.push_back(0);
    endtask

    // Card model: answers each send after a delay.
    int         card_d;
    logic [7:0] card_r;
    initial forever begin
        @(negedge iClk);
        if (iRstN && oSpiSend) begin
            card_d = (card_delay != 0) ? card_delay : int'($urandom_range(1, 3));
            card_r = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hFF;
            repeat (card_d) @(negedge iClk);
            iSpiRx    = card_r;
            iSpiAvail = 1'b1;
            @(negedge iClk);
            iSpiAvail = 1'b0;
        end
    end

    // Monitors
    tx_t         mon_t;
    logic [16:0] mon_d;
    int          mon_e;
    always @(negedge iClk) begin
        if (iRstN) begin
            if (oSpiSend) begin
                sends_seen++;
                check("send_expected", 32'(exp_tx.size() != 0), 1);
                if (exp_tx.size() != 0) begin
                    mon_t = exp_tx.pop_front();
                    check("spi_tx", oSpiTx, mon_t.b);
                    check("cs_at_send", oSdCs, mon_t.cs);
                end
            end
            if (oValid) begin
                check("valid_expected", 32'(exp_data.size() != 0), 1);
                if (exp_data.size() != 0) begin
                    mon_d = exp_data.pop_front();
                    check("data", oData, mon_d[7:0]);
                    check("idx", oIdx, mon_d[16:8]);
                end
            end
            if (oDone || oError) begin
                ends_seen++;
                check("end_expected", 32'(exp_end.size() != 0), 1);
                if (exp_end.size() != 0) begin
                    mon_e = exp_end.pop_front();
                    check("end_kind", {oError, oDone, oErrCode},
                          {(mon_e != 0), (mon_e == 0), 3'(mon_e)});
                    check("busy_at_end", oBusy, 0);
                    check("cs_at_end", oSdCs, 1);
                end
            end
        end
    end

    task automatic start_read(input logic [31:0] lba, input logic sdhc);
        @(negedge iClk);
        iLba = lba; iSdhc = sdhc; iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        check("busy_after_start", oBusy, 1);
    endtask

    task automatic wait_end(input int budget);
        int target, n;
        target = ends_seen + 1;
        n = 0;
        while (ends_seen < target && n < budget) begin
            @(negedge iClk);
            n++;
        end
        check("end_within_budget", 32'(ends_seen >= target), 1);
    endtask

    task automatic drain_check(input string name);
        repeat (10) @(negedge iClk);
        check({name, "_tx_left"}, exp_tx.size(), 0);
        check({name, "_data_left"}, exp_data.size(), 0);
        check({name, "_end_left"}, exp_end.size(), 0);
        flush();
    endtask

    task automatic wait_idx(input logic [8:0] idx, input int budget);
        int n;
        bit hit;
        n = 0; hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge iClk);
            n++;
            if (oValid && oIdx == idx) hit = 1'b1;
        end
        check("reached_idx", 32'(hit), 1);
    endtask

    initial begin
        int          n, base, kind;
        bit          early;
        logic [31:0] lba;
        logic        sdhc;

        repeat (3) @(negedge iClk);
        check("rst_cs", oSdCs, 1);
        check("rst_send", oSpiSend, 0);
        check("rst_tx", oSpiTx, 8'hFF);
        check("rst_busy", oBusy, 0);
        check("rst_done", oDone, 0);
        check("rst_error", oError, 0);
        check("rst_valid", oValid, 0);
        check("rst_errcode", oErrCode, 0);
        check("rst_data", oData, 0);
        check("rst_idx", oIdx, 0);
        iRstN = 1'b1;
        repeat (2) @(negedge iClk);

        // SDHC read, R1 on 2nd poll, token after 3 polls, ramp payload.
        build_read(32'h0000_1234, 1'b1, 1, 8'h00, 2, 8'hFE, 1'b1);
        start_read(32'h0000_1234, 1'b1);
        wait_end(10000);
        drain_check("sdhc");

        // SDSC read of LBA 5, with an ignored iStart during DATA.
        build_read(32'd5, 1'b0, 0, 8'h00, 0, 8'hFE, 1'b0);
        start_read(32'd5, 1'b0);
        wait_idx(9'd50, 2000);
        iLba = 32'hDEAD_BEEF; iSdhc = 1'b1; iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        check("busy_during_data", oBusy, 1);
        wait_end(10000);
        drain_check("sdsc");

        // R1 error, R1 timeout, token error, token timeout, bad token.
        build_read(32'h77, 1'b1, 0, 8'h04, 0, 8'hFE, 1'b0);
        start_read(32'h77, 1'b1);
        wait_end(1000);
        drain_check("r1_err");

        build_read(32'h78, 1'b1, 0, 8'hFF, 0, 8'hFE, 1'b0);
        start_read(32'h78, 1'b1);
        wait_end(1000);
        drain_check("r1_timeout");

        build_read(32'h79, 1'b1, 0, 8'h00, 1, 8'h08, 1'b0);
        start_read(32'h79, 1'b1);
        wait_end(1000);
        drain_check("token_err");

        card_delay = 1;
        build_read(32'h7A, 1'b1, 2, 8'h00, 0, 8'hFF, 1'b0);
        start_read(32'h7A, 1'b1);
        wait_end(30000);
        drain_check("token_timeout");
        card_delay = 0;

        build_read(32'h7B, 1'b0, 0, 8'h00, 0, 8'h3C, 1'b0);
        start_read(32'h7B, 1'b0);
        wait_end(1000);
        drain_check("bad_token");

        // Abort with a slow outstanding byte at DATA index 100.
        build_read(32'h100, 1'b1, 0, 8'h00, 0, 8'hFE, 1'b0);
        start_read(32'h100, 1'b1);
        wait_idx(9'd99, 2000);
        card_delay = 20;
        base = sends_seen;
        n = 0;
        while (sends_seen == base && n < 20) begin @(negedge iClk); n++; end
        check("abort_byte_sent", 32'(sends_seen > base), 1);
        repeat (2) @(negedge iClk);
        iAbort = 1'b1;
        @(negedge iClk);
        iAbort = 1'b0;
        flush();
        check("abort_cs_held", oSdCs, 0);
        check("abort_busy_held", oBusy, 1);
        n = 0; early = 1'b0;
        while (n < 40) begin
            @(posedge iClk);
            if (iSpiAvail) break;
            if (oSdCs) early = 1'b1;
            n++;
        end
        check("abort_avail_seen", 32'(n < 40), 1);
        check("abort_cs_early", 32'(early), 0);
        #1;
        check("abort_cs_released", oSdCs, 1);
        check("abort_busy_cleared", oBusy, 0);
        card_delay = 0;
        repeat (30) @(negedge iClk);
        drain_check("abort");

        build_read(32'h200, 1'b0, 3, 8'h00, 5, 8'hFE, 1'b0);
        start_read(32'h200, 1'b0);
        wait_end(10000);
        drain_check("after_abort");

        // Asynchronous reset in the middle of the command.
        build_read(32'h300, 1'b1, 0, 8'h00, 0, 8'hFE, 1'b0);
        start_read(32'h300, 1'b1);
        base = sends_seen;
        n = 0;
        while (sends_seen < base + 2 && n < 50) begin @(negedge iClk); n++; end
        check("cmd_sends_seen", 32'(sends_seen >= base + 2), 1);
        flush();
        #2 iRstN = 1'b0;
        #1;
        check("arst_cs", oSdCs, 1);
        check("arst_busy", oBusy, 0);
        check("arst_send", oSpiSend, 0);
        check("arst_tx", oSpiTx, 8'hFF);
        repeat (3) @(negedge iClk);
        iRstN = 1'b1;
        repeat (10) @(negedge iClk);
        rx_q.delete();

        // Randomised reads: successes and error endings.
        for (int r = 0; r < 4; r++) begin
            lba  = $urandom;
            sdhc = 1'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 3));
            case (kind)
                2:       build_read(lba, sdhc, int'($urandom_range(0, 4)),
                                    8'($urandom_range(1, 127)), 0, 8'hFE, 1'b0);
                3:       build_read(lba, sdhc, 0, 8'h00, int'($urandom_range(0, 10)),
                                    8'($urandom_range(0, 1) != 0 ? $urandom_range(1, 15)
                                                                 : $urandom_range(16, 253)),
                                    1'b0);
                default: build_read(lba, sdhc, int'($urandom_range(0, 4)), 8'h00,
                                    int'($urandom_range(0, 10)), 8'hFE, 1'b0);
            endcase
            start_read(lba, sdhc);
            wait_end(10000);
            drain_check("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
